// File: rtl/pcg_rng_bank.sv
// pcg_rng_bank: multi-channel PCG32 generator bank behind a Wishbone classic
// slave port. Each channel holds a 64-bit LCG state, multiplier and increment,
// and a small FIFO of pre-generated XSH-RR outputs. One shared step engine
// visits the channels round-robin and fills any FIFO that is not full.
//
// Register map per channel (adr[5:3] = channel, adr[2:0] = offset):
//   0 OUT (R, pops FIFO)   1 STATUS (R: [3:0] level, [8] underflow; W1C [8])
//   2 SEED_HI 3 SEED_LO    4 MUL_HI 5 MUL_LO    6 INC_HI 7 INC_LO
//   HI writes fill a per-channel shadow; LO writes commit {shadow, dat_w}.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cyc, stb, we, sel Wishbone request
//   adr, dat_w        word address and write data
//   dat_r, ack        registered read data and single-cycle acknowledge
//
// Build option: PCG_BANK_STALL_EN -- an OUT read of an empty FIFO holds off
// ack until data arrives instead of returning 0 and flagging underflow.
module pcg_rng_bank #(
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    output logic        ack
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [63:0] STATE_RST = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] MUL_RST   = 64'h5851_F42D_4C95_7F2D;
    localparam logic [63:0] INC_RST   = 64'h1405_7B7E_F767_814F;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [63:0]   state_q [CHANNELS], state_d [CHANNELS];
    logic [63:0]   mul_q   [CHANNELS], mul_d   [CHANNELS];
    logic [63:0]   inc_q   [CHANNELS], inc_d   [CHANNELS];
    logic [31:0]   shadow_q[CHANNELS], shadow_d[CHANNELS];
    logic [31:0]   fifo_q  [CHANNELS][FIFO_DEPTH];
    logic [31:0]   fifo_d  [CHANNELS][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q[CHANNELS], rd_ptr_d[CHANNELS];
    logic [AW-1:0] wr_ptr_q[CHANNELS], wr_ptr_d[CHANNELS];
    logic [LW-1:0] level_q [CHANNELS], level_d [CHANNELS];
    logic [CHANNELS-1:0] uf_q, uf_d;
    logic [CW-1:0] rr_q, rr_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_r_q, dat_r_d;

    logic [2:0]    ch_idx, off;
    logic          ch_ok, is_out_rd, ready, req, wr_ok;
    logic          addr_empty, addr_uf;
    logic [31:0]   addr_head, rd_data;
    logic [LW-1:0] addr_level;
    logic [CHANNELS-1:0] hit, commit, pop, uf_set, grant;
    logic          found;
    int            grant_ch, cand;
    logic          unused_adr;

    assign unused_adr = ^adr[31:6];

    // XSH-RR permutation of the pre-step state.
    function automatic logic [31:0] pcg_out(input logic [63:0] s);
        logic [63:0] xs;
        logic [63:0] rot;
        xs  = ((s >> 18) ^ s) >> 27;
        rot = {xs[31:0], xs[31:0]} >> s[63:59];
        return rot[31:0];
    endfunction

    // Bus decode
    always_comb begin
        ch_idx     = adr[5:3];
        off        = adr[2:0];
        ch_ok      = (int'(ch_idx) < CHANNELS);
        hit        = '0;
        addr_empty = 1'b1;
        addr_head  = '0;
        addr_level = '0;
        addr_uf    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 3'(c)) begin
                hit[c]     = 1'b1;
                addr_empty = (level_q[c] == '0);
                addr_head  = fifo_q[c][rd_ptr_q[c]];
                addr_level = level_q[c];
                addr_uf    = uf_q[c];
            end
        end
        is_out_rd = ~we & (off == 3'd0) & ch_ok;
`ifdef PCG_BANK_STALL_EN
        ready = ~(is_out_rd & addr_empty);
`else
        ready = 1'b1;
`endif
        req   = cyc & stb & ~ack_q & ready;
        wr_ok = req & we & (sel == 4'hF) & ch_ok;
        for (int c = 0; c < CHANNELS; c++) begin
            commit[c] = wr_ok & hit[c] & ((off == 3'd3) | (off == 3'd5) | (off == 3'd7));
            pop[c]    = req & is_out_rd & hit[c] & (level_q[c] != '0);
            // Only reachable without the stall option: ready gates it otherwise.
            uf_set[c] = req & is_out_rd & hit[c] & (level_q[c] == '0);
        end
        rd_data = '0;
        if (ch_ok) begin
            case (off)
                3'd0:    rd_data = addr_empty ? 32'd0 : addr_head;
                3'd1:    rd_data = {23'd0, addr_uf, 4'd0, 4'(addr_level)};
                default: rd_data = '0;
            endcase
        end
        ack_d   = req;
        dat_r_d = (req & ~we) ? rd_data : 32'd0;
    end

    // Round-robin step engine: first non-full channel from rr_q that is not
    // being committed this cycle.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        grant_ch = 0;
        cand     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = (int'(rr_q) + i) % CHANNELS;
            if (!found && (level_q[cand] != LVL_FULL) && !commit[cand]) begin
                found       = 1'b1;
                grant_ch    = cand;
                grant[cand] = 1'b1;
            end
        end
        rr_d = rr_q;
        if (found) begin
            rr_d = (grant_ch == CHANNELS - 1) ? '0 : CW'(grant_ch + 1);
        end
    end

    // Per-channel next state
    always_comb begin
        uf_d = uf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c]  = state_q[c];
            mul_d[c]    = mul_q[c];
            inc_d[c]    = inc_q[c];
            shadow_d[c] = shadow_q[c];
            fifo_d[c]   = fifo_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            level_d[c]  = level_q[c];
            if (commit[c]) begin
                case (off)
                    3'd3:    state_d[c] = {shadow_q[c], dat_w};
                    3'd5:    mul_d[c]   = {shadow_q[c], dat_w};
                    default: inc_d[c]   = {shadow_q[c], dat_w[31:1], 1'b1};
                endcase
                rd_ptr_d[c] = '0;
                wr_ptr_d[c] = '0;
                level_d[c]  = '0;
            end else begin
                if (grant[c]) begin
                    fifo_d[c][wr_ptr_q[c]] = pcg_out(state_q[c]);
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                    state_d[c]  = state_q[c] * mul_q[c] + inc_q[c];
                end
                if (pop[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                level_d[c] = level_q[c] + LW'(grant[c]) - LW'(pop[c]);
            end
            if (wr_ok && hit[c] && ((off == 3'd2) || (off == 3'd4) || (off == 3'd6))) begin
                shadow_d[c] = dat_w;
            end
            if (uf_set[c]) begin
                uf_d[c] = 1'b1;
            end else if (wr_ok && hit[c] && (off == 3'd1) && dat_w[8]) begin
                uf_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= STATE_RST;
                mul_q[c]    <= MUL_RST;
                inc_q[c]    <= INC_RST + 64'(2 * c);
                shadow_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                level_q[c]  <= '0;
            end
            uf_q    <= '0;
            rr_q    <= '0;
            ack_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q  <= state_d;
            mul_q    <= mul_d;
            inc_q    <= inc_d;
            shadow_q <= shadow_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            uf_q     <= uf_d;
            rr_q     <= rr_d;
            ack_q    <= ack_d;
            dat_r_q  <= dat_r_d;
        end
    end

    // FIFO storage needs no reset: entries are only visible below the level.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign ack   = ack_q;
    assign dat_r = dat_r_q;

endmodule

// File: tb/tb_pcg_rng_bank.sv
module tb_pcg_rng_bank;
    localparam int CH    = 3;
    localparam int DEPTH = 4;
    localparam int SETTLE = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_w = '0;
    logic [31:0] dat_r;
    logic        ack;

    int n_checks = 0;
    int n_errors = 0;

    pcg_rng_bank #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
        .adr(adr), .dat_w(dat_w), .dat_r(dat_r), .ack(ack)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, m_state is the state whose output the next
    // OUT read returns.
    logic [63:0] m_state [CH];
    logic [63:0] m_mul   [CH];
    logic [63:0] m_inc   [CH];
    logic [31:0] m_shadow[CH];
    bit          m_uf    [CH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_out(input logic [63:0] s);
        logic [63:0] t;
        logic [31:0] x;
        int r;
        t = ((s / 64'd262144) ^ s) / 64'd134217728;
        x = t[31:0];
        r = int'(s / 64'h0800_0000_0000_0000);
        for (int k = 0; k < r; k++) x = {x[0], x[31:1]};
        return x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_state[c]  = 64'h1234_5678_9ABC_DEF0;
            m_mul[c]    = 64'h5851_F42D_4C95_7F2D;
            m_inc[c]    = 64'h1405_7B7E_F767_814F + 64'(2 * c);
            m_shadow[c] = '0;
            m_uf[c]     = 1'b0;
        end
    endtask

    // The FIFO is full whenever a MUL/INC commit lands (bench always settles),
    // so the engine has already stepped DEPTH times past the next unread value.
    task automatic model_advance(input int ch);
        for (int k = 0; k < DEPTH; k++) m_state[ch] = m_state[ch] * m_mul[ch] + m_inc[ch];
    endtask

    task automatic model_write(input int ch, input int off, input logic [31:0] d, input logic [3:0] s);
        if (ch >= CH || s != 4'hF) return;
        case (off)
            1: if (d[8]) m_uf[ch] = 1'b0;
            2, 4, 6: m_shadow[ch] = d;
            3: m_state[ch] = {m_shadow[ch], d};
            5: begin model_advance(ch); m_mul[ch] = {m_shadow[ch], d}; end
            7: begin model_advance(ch); m_inc[ch] = {m_shadow[ch], d} | 64'd1; end
            default: ;
        endcase
    endtask

    task automatic model_read(input int ch, input int off, output logic [31:0] exp);
        exp = '0;
        if (ch >= CH) return;
        if (off == 0) begin
            exp = ref_out(m_state[ch]);
            m_state[ch] = m_state[ch] * m_mul[ch] + m_inc[ch];
        end else if (off == 1) begin
            exp = 32'(DEPTH) | (m_uf[ch] ? 32'h100 : 32'h0);
        end
    endtask

    function automatic logic [31:0] mk_adr(input int ch, input int off, input logic [31:0] hi);
        return (hi & 32'hFFFF_FFC0) | (32'(ch) << 3) | 32'(off);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) check("ack_timeout", 64'(got), 64'd1);
    endtask

    task automatic wr(input int ch, input int off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        bus(1'b1, mk_adr(ch, off, $urandom), d, s, rd);
        model_write(ch, off, d, s);
        idle(SETTLE);
    endtask

    task automatic rd_chk(input int ch, input int off, input string tag, output logic [31:0] got);
        logic [31:0] exp;
        model_read(ch, off, exp);
        bus(1'b0, mk_adr(ch, off, $urandom), '0, 4'hF, got);
        check(tag, 64'(got), 64'(exp));
        @(negedge clk);
        check({tag, "_dat_r_clr"}, 64'({ack, dat_r}), 64'd0);
        idle(SETTLE);
    endtask

    logic [31:0] v;
    int          r_ch, r_off, n_ack;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_d;

    initial begin
        model_reset();
        idle(3);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat_r", 64'(dat_r), 64'd0);
        rst_n = 1'b1;
        idle(20);

        rd_chk(0, 1, "status0_rst", v);
        check("status0_level4", 64'(v), 64'h4);
        rd_chk(1, 1, "status1_rst", v);
        for (int c = 0; c < CH; c++) rd_chk(c, 0, "out_rst", v);
        rd_chk(0, 0, "out_rst_ch0_2nd", v);

        // ch0: identity multiplier, increment forced odd, top-heavy seed
        wr(0, 4, 32'h0, 4'hF);
        wr(0, 5, 32'h1, 4'hF);
        wr(0, 6, 32'h0, 4'hF);
        wr(0, 7, 32'h0, 4'hF);
        wr(0, 2, 32'hF800_0000, 4'hF);
        wr(0, 3, 32'h0, 4'hF);
        rd_chk(0, 0, "ch0_out_a", v);
        check("ch0_out_a_const", 64'(v), 64'h000F_8000);
        rd_chk(0, 0, "ch0_out_b", v);
        check("ch0_out_b_const", 64'(v), 64'h000F_8000);

        // ch1: seed 1<<32
        wr(1, 4, 32'h0, 4'hF);
        wr(1, 5, 32'h1, 4'hF);
        wr(1, 6, 32'h0, 4'hF);
        wr(1, 7, 32'h1, 4'hF);
        wr(1, 2, 32'h1, 4'hF);
        wr(1, 3, 32'h0, 4'hF);
        rd_chk(1, 0, "ch1_out", v);
        check("ch1_out_const", 64'(v), 64'h20);
        rd_chk(0, 0, "ch0_unaffected", v);

        // ch1: even increment becomes odd; high-state seed makes outputs visible
        wr(1, 6, 32'h0, 4'hF);
        wr(1, 7, 32'h4, 4'hF);
        wr(1, 2, 32'h4000_0000, 4'hF);
        wr(1, 3, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) rd_chk(1, 0, "ch1_inc5", v);

        // sel != F ignored; invalid channels and write-only offsets read 0
        wr(0, 3, 32'hDEAD_BEEF, 4'h7);
        rd_chk(0, 0, "sel_partial_ignored", v);
        wr(7, 3, 32'h1234_5678, 4'hF);
        rd_chk(7, 5, "ch7_off5", v);
        rd_chk(CH, 0, "ch_boundary_out", v);
        rd_chk(2, 4, "wo_reg_reads0", v);

        // held strobe: one ack, idle cycle, next ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(2, 1, 0); sel = 4'hF;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_stb_acks", 64'(n_ack), 64'd2);
        idle(SETTLE);

        // Empty-FIFO read: flush ch1, ch2, ch0 back to back so the engine is
        // busy on ch1/ch2 and ch0 is still empty when its OUT read lands.
        wr(0, 2, 32'hC000_0000, 4'hF);
        wr(1, 2, 32'h0000_0003, 4'hF);
        wr(2, 2, 32'h0000_0005, 4'hF);
        bus(1'b1, mk_adr(1, 3, 0), 32'h11, 4'hF, v);
        model_write(1, 3, 32'h11, 4'hF);
        bus(1'b1, mk_adr(2, 3, 0), 32'h22, 4'hF, v);
        model_write(2, 3, 32'h22, 4'hF);
        bus(1'b1, mk_adr(0, 3, 0), 32'h1, 4'hF, v);
        model_write(0, 3, 32'h1, 4'hF);
        bus(1'b0, mk_adr(0, 0, 0), '0, 4'hF, v);
`ifdef PCG_BANK_STALL_EN
        check("stall_out", 64'(v), 64'(ref_out(m_state[0])));
        m_state[0] = m_state[0] * m_mul[0] + m_inc[0];
`else
        check("underflow_out", 64'(v), 64'd0);
        m_uf[0] = 1'b1;
`endif
        idle(SETTLE);
        rd_chk(0, 1, "uf_status", v);
        wr(0, 1, 32'h100, 4'hF);
        rd_chk(0, 1, "uf_cleared", v);
        rd_chk(0, 0, "after_uf_out", v);

        // Reset while an ack is pending
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(1, 0, 0); sel = 4'hF;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_drops_ack", 64'(ack), 64'd0);
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("rst_no_late_ack", 64'({ack, dat_r}), 64'd0);
        model_reset();
        idle(SETTLE);
        for (int c = 0; c < CH; c++) rd_chk(c, 0, "out_after_rst", v);
        rd_chk(1, 1, "status_after_rst", v);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            r_ch  = ($urandom_range(0, 7) == 0) ? $urandom_range(CH, 7) : $urandom_range(0, CH - 1);
            r_off = $urandom_range(0, 7);
            r_we  = 1'($urandom_range(0, 1));
            r_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            r_d   = $urandom;
            if (r_we) wr(r_ch, r_off, r_d, r_sel);
            else      rd_chk(r_ch, r_off, "rand_rd", v);
        end
        for (int c = 0; c < CH; c++) rd_chk(c, 0, "final_out", v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
